id_stage_pipe: RTL and testbench

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

---
 rtl/id_stage_pipe.sv | 181 ++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage with operand forwarding, hazard stall and a registered ready/valid output slot
//
// Ports:
//    clk, rst_                  clock, synchronous active-low reset
//    id_i_valid/_ready/_pc/_inst  instruction input handshake
//    reg0_addr/reg1_addr        regfile read addresses (rs / rt fields)
//    reg0_data/reg1_data        regfile read data, same cycle
//    fwd_wreg/_waddr/_wdata/_load  forwarding sources, index 0 youngest (EX)
//    flush                      drop the input and invalidate the output slot
//    id_o_valid/_ready          output handshake
//    id_o_alu_op/_alu_sel/_reg0/_reg1/_waddr/_wreg/_pc/_illegal  registered decode result
//
// Build option: define ID_FWD_EN to forward results from the sources; when it is
// undefined any enabled source matching a used read port stalls the stage.
module id_stage_pipe #(
   parameter int DATA_W  = 32,
   parameter int NUM_FWD = 2
) (
   input  logic                      clk,
   input  logic                      rst_,
   input  logic                      id_i_valid,
   output logic                      id_i_ready,
   input  logic [31:0]               id_i_pc,
   input  logic [31:0]               id_i_inst,
   output logic [4:0]                reg0_addr,
   output logic [4:0]                reg1_addr,
   input  logic [DATA_W-1:0]         reg0_data,
   input  logic [DATA_W-1:0]         reg1_data,
   input  logic [NUM_FWD-1:0]        fwd_wreg,
   input  logic [5*NUM_FWD-1:0]      fwd_waddr,
   input  logic [DATA_W*NUM_FWD-1:0] fwd_wdata,
   input  logic [NUM_FWD-1:0]        fwd_load,
   input  logic                      flush,
   output logic                      id_o_valid,
   input  logic                      id_o_ready,
   output logic [7:0]                id_o_alu_op,
   output logic [2:0]                id_o_alu_sel,
   output logic [DATA_W-1:0]         id_o_reg0,
   output logic [DATA_W-1:0]         id_o_reg1,
   output logic [4:0]                id_o_waddr,
   output logic                      id_o_wreg,
   output logic [31:0]               id_o_pc,
   output logic                      id_o_illegal
);
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;

   logic [5:0]        opc, func;
   logic [15:0]       imm;
   logic              is_special, is_imm, is_lui, legal, use0, use1;
   logic [7:0]        alu_op;
   logic [4:0]        waddr;
   logic [DATA_W-1:0] src0, src1, op0, op1;
   logic              hit0, hit1, stall, xfer;

   logic              valid_q, valid_d, wreg_q, wreg_d, illegal_q, illegal_d;
   logic [7:0]        alu_op_q, alu_op_d;
   logic [2:0]        alu_sel_q, alu_sel_d;
   logic [DATA_W-1:0] reg0_q, reg0_d, reg1_q, reg1_d;
   logic [4:0]        waddr_q, waddr_d;
   logic [31:0]       pc_q, pc_d;

   assign opc       = id_i_inst[31:26];
   assign func      = id_i_inst[5:0];
   assign imm       = id_i_inst[15:0];
   assign reg0_addr = id_i_inst[25:21];
   assign reg1_addr = id_i_inst[20:16];

   // SPECIAL functions 0x24..0x27 share the prefix 4'b1001
   assign is_special = (opc == OP_SPECIAL) && (func[5:2] == 4'b1001);
   assign is_imm     = (opc == OP_ANDI) || (opc == OP_ORI) || (opc == OP_XORI);
   assign is_lui     = (opc == OP_LUI);
   assign legal      = is_special | is_imm | is_lui;
   // Only ports an instruction actually reads can create a hazard (rt is a destination for immediates)
   assign use0       = is_special | is_imm;
   assign use1       = is_special;

   assign alu_op = is_special      ? {2'b00, func} :
                   opc == OP_ANDI  ? 8'h24 :
                   opc == OP_XORI  ? 8'h26 :
                   legal           ? 8'h25 : 8'h00;
   assign waddr  = is_special ? id_i_inst[15:11] : legal ? id_i_inst[20:16] : 5'd0;

   // Walk sources oldest to youngest so the youngest match overrides the data
   always_comb begin
      src0 = reg0_data;
      src1 = reg1_data;
      hit0 = 1'b0;
      hit1 = 1'b0;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if (fwd_wreg[k] && fwd_waddr[5*k +: 5] == reg0_addr) begin
`ifdef ID_FWD_EN
            src0 = fwd_wdata[DATA_W*k +: DATA_W];
            hit0 = hit0 | fwd_load[k];
`else
            hit0 = 1'b1;
`endif
         end
         if (fwd_wreg[k] && fwd_waddr[5*k +: 5] == reg1_addr) begin
`ifdef ID_FWD_EN
            src1 = fwd_wdata[DATA_W*k +: DATA_W];
            hit1 = hit1 | fwd_load[k];
`else
            hit1 = 1'b1;
`endif
         end
      end
      if (reg0_addr == 5'd0) begin
         src0 = '0;
         hit0 = 1'b0;
      end
      if (reg1_addr == 5'd0) begin
         src1 = '0;
         hit1 = 1'b0;
      end
   end

`ifndef ID_FWD_EN
   logic unused_fwd;
   assign unused_fwd = ^{fwd_wdata, fwd_load};
`endif

   assign op0 = use0 ? src0 : '0;
   assign op1 = is_special ? src1 :
                is_imm     ? DATA_W'(imm) :
                is_lui     ? DATA_W'({imm, 16'h0000}) : '0;

   assign stall      = (use0 & hit0) | (use1 & hit1);
   assign id_i_ready = rst_ & (flush | ((~valid_q | id_o_ready) & ~stall));
   // A flush accepts the instruction only to throw it away
   assign xfer       = id_i_valid & id_i_ready & ~flush;

   always_comb begin
      valid_d   = ~flush & (xfer | (valid_q & ~id_o_ready));
      alu_op_d  = xfer ? alu_op : alu_op_q;
      alu_sel_d = xfer ? {2'b00, legal} : alu_sel_q;
      reg0_d    = xfer ? op0 : reg0_q;
      reg1_d    = xfer ? op1 : reg1_q;
      waddr_d   = xfer ? waddr : waddr_q;
      wreg_d    = xfer ? legal : wreg_q;
      pc_d      = xfer ? id_i_pc : pc_q;
      illegal_d = xfer ? ~legal : illegal_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         valid_q   <= 1'b0;
         alu_op_q  <= '0;
         alu_sel_q <= '0;
         reg0_q    <= '0;
         reg1_q    <= '0;
         waddr_q   <= '0;
         wreg_q    <= 1'b0;
         pc_q      <= '0;
         illegal_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         alu_op_q  <= alu_op_d;
         alu_sel_q <= alu_sel_d;
         reg0_q    <= reg0_d;
         reg1_q    <= reg1_d;
         waddr_q   <= waddr_d;
         wreg_q    <= wreg_d;
         pc_q      <= pc_d;
         illegal_q <= illegal_d;
      end
   end

   assign id_o_valid   = valid_q;
   assign id_o_alu_op  = alu_op_q;
   assign id_o_alu_sel = alu_sel_q;
   assign id_o_reg0    = reg0_q;
   assign id_o_reg1    = reg1_q;
   assign id_o_waddr   = waddr_q;
   assign id_o_wreg    = wreg_q;
   assign id_o_pc      = pc_q;
   assign id_o_illegal = illegal_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: randomized and directed checks of id_stage_pipe against a behavioural model
module tb_id_stage_pipe;
   logic        clk = 1'b0;
   logic        rst_, id_i_valid, id_i_ready, flush, id_o_ready;
   logic [31:0] id_i_pc, id_i_inst;
   logic [4:0]  reg0_addr, reg1_addr;
   logic [31:0] reg0_data, reg1_data;
   logic [1:0]  fwd_wreg, fwd_load;
   logic [9:0]  fwd_waddr;
   logic [63:0] fwd_wdata;
   logic        id_o_valid, id_o_wreg, id_o_illegal;
   logic [7:0]  id_o_alu_op;
   logic [2:0]  id_o_alu_sel;
   logic [31:0] id_o_reg0, id_o_reg1, id_o_pc;
   logic [4:0]  id_o_waddr;
   logic [31:0] rf [32];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign reg0_data = rf[reg0_addr];
   assign reg1_data = rf[reg1_addr];

   id_stage_pipe #(.DATA_W(32), .NUM_FWD(2)) dut (
      .clk(clk), .rst_(rst_), .id_i_valid(id_i_valid), .id_i_ready(id_i_ready),
      .id_i_pc(id_i_pc), .id_i_inst(id_i_inst), .reg0_addr(reg0_addr), .reg1_addr(reg1_addr),
      .reg0_data(reg0_data), .reg1_data(reg1_data), .fwd_wreg(fwd_wreg), .fwd_waddr(fwd_waddr),
      .fwd_wdata(fwd_wdata), .fwd_load(fwd_load), .flush(flush), .id_o_valid(id_o_valid),
      .id_o_ready(id_o_ready), .id_o_alu_op(id_o_alu_op), .id_o_alu_sel(id_o_alu_sel),
      .id_o_reg0(id_o_reg0), .id_o_reg1(id_o_reg1), .id_o_waddr(id_o_waddr),
      .id_o_wreg(id_o_wreg), .id_o_pc(id_o_pc), .id_o_illegal(id_o_illegal)
   );

   typedef struct packed {
      logic        v, ill, wr;
      logic [7:0]  op;
      logic [2:0]  sel;
      logic [31:0] r0, r1;
      logic [4:0]  wa;
      logic [31:0] pc;
   } out_t;

   out_t m;
   bit   mzero;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Value an instruction sees for a source register, and whether it must wait for it
   function automatic void operand(input logic [4:0] a, output logic [31:0] val, output bit st);
`ifdef ID_FWD_EN
      bit found = 0;
`endif
      val = (a == 5'd0) ? 32'h0 : rf[a];
      st  = 0;
      if (a != 5'd0)
         for (int k = 0; k < 2; k++)
            if (fwd_wreg[k] && fwd_waddr[5*k +: 5] == a) begin
`ifdef ID_FWD_EN
               if (!found) val = fwd_wdata[32*k +: 32];
               found = 1;
               if (fwd_load[k]) st = 1;
`else
               st = 1;
`endif
            end
   endfunction

   function automatic void decode(input logic [31:0] ins, input logic [31:0] pc_in,
                                  output out_t o, output bit st);
      logic [31:0] a, b;
      bit sa, sb;
      logic [5:0] opc, fn;
      opc = ins[31:26];
      fn  = ins[5:0];
      o = '0;
      o.v = 1;
      o.pc = pc_in;
      st = 0;
      if (opc == 6'h00 && fn >= 6'h24 && fn <= 6'h27) begin
         operand(ins[25:21], a, sa);
         operand(ins[20:16], b, sb);
         o.op = {2'b00, fn}; o.r0 = a; o.r1 = b; o.wa = ins[15:11];
         o.wr = 1; o.sel = 3'b001; st = sa | sb;
      end else if (opc >= 6'h0C && opc <= 6'h0E) begin
         operand(ins[25:21], a, sa);
         o.op = (opc == 6'h0C) ? 8'h24 : (opc == 6'h0D) ? 8'h25 : 8'h26;
         o.r0 = a; o.r1 = {16'h0, ins[15:0]}; o.wa = ins[20:16];
         o.wr = 1; o.sel = 3'b001; st = sa;
      end else if (opc == 6'h0F) begin
         o.op = 8'h25; o.r1 = {ins[15:0], 16'h0}; o.wa = ins[20:16];
         o.wr = 1; o.sel = 3'b001;
      end else
         o.ill = 1;
   endfunction

   // One cycle: compare the DUT with the model before the edge, then advance the model
   task automatic step();
      out_t d;
      bit st, er;
      @(negedge clk);
      decode(id_i_inst, id_i_pc, d, st);
      er = !rst_ ? 1'b0 : flush ? 1'b1 : ((!m.v || id_o_ready) && !st);
      chk("id_i_ready", id_i_ready, er);
      chk("reg0_addr", reg0_addr, id_i_inst[25:21]);
      chk("reg1_addr", reg1_addr, id_i_inst[20:16]);
      chk("id_o_valid", id_o_valid, m.v);
      if (m.v || mzero) begin
         chk("alu_op", id_o_alu_op, m.op);
         chk("alu_sel", id_o_alu_sel, m.sel);
         chk("reg0", id_o_reg0, m.r0);
         chk("reg1", id_o_reg1, m.r1);
         chk("waddr", id_o_waddr, m.wa);
         chk("wreg", id_o_wreg, m.wr);
         chk("pc", id_o_pc, m.pc);
         chk("illegal", id_o_illegal, m.ill);
      end
      if (!rst_) begin
         m = '0;
         mzero = 1;
      end else begin
         mzero = 0;
         if (flush) m.v = 0;
         else if (id_i_valid && er) m = d;
         else if (!m.v || id_o_ready) m.v = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_fwd();
      fwd_wreg = '0; fwd_load = '0; fwd_waddr = '0; fwd_wdata = '0;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [4:0] rs, rt, rd;
      logic [15:0] imm;
      int r;
      r = $urandom_range(0, 9);
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 31));
      imm = 16'($urandom);
      case (r)
         0, 1, 2, 3: return {6'h00, rs, rt, rd, 5'd0, 6'(6'h24 + r)};
         4:          return {6'h0C, rs, rt, imm};
         5:          return {6'h0D, rs, rt, imm};
         6:          return {6'h0E, rs, rt, imm};
         7:          return {6'h0F, rs, rt, imm};
         8:          return {6'h00, rs, rt, rd, 5'd0, 6'($urandom)};
         default:    return $urandom;
      endcase
   endfunction

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      rst_ = 0; id_i_valid = 0; flush = 0; id_o_ready = 1;
      id_i_pc = 32'h100; id_i_inst = 32'h0;
      idle_fwd();
      @(posedge clk);
      #1;
      m = '0;
      mzero = 1;
      step();
      chk("reset_ready", id_i_ready, 1'b0);
      chk("reset_valid", id_o_valid, 1'b0);
      chk("reset_reg1", id_o_reg1, 32'h0);
      rst_ = 1;

      // ORI r1,r0,0xFF00
      id_i_valid = 1; id_i_inst = 32'h3401FF00; id_i_pc = 32'h200;
      step();
      chk("ori_valid", id_o_valid, 1'b1);
      chk("ori_reg0", id_o_reg0, 32'h0);
      chk("ori_reg1", id_o_reg1, 32'h0000FF00);
      chk("ori_alu_op", id_o_alu_op, 8'h25);
      chk("ori_waddr", id_o_waddr, 5'd1);
      chk("ori_wreg", id_o_wreg, 1'b1);

      // OR r3,r1,r2 with EX r1=0xA, MEM r1=0xB
      rf[2] = 32'h5;
      id_i_inst = 32'h00221825;
      fwd_wreg = 2'b11; fwd_waddr = {5'd1, 5'd1}; fwd_wdata = {32'hB, 32'hA};
      #1;
`ifdef ID_FWD_EN
      step();
      chk("or_fwd_reg0", id_o_reg0, 32'hA);
      chk("or_fwd_reg1", id_o_reg1, 32'h5);
`else
      chk("nofwd_stall_ready", id_i_ready, 1'b0);
      step();
      chk("nofwd_stall_bubble", id_o_valid, 1'b0);
`endif

      // ANDI r2,r1,1 behind a load in EX
      idle_fwd();
      fwd_wreg = 2'b01; fwd_waddr = {5'd0, 5'd1}; fwd_load = 2'b01; fwd_wdata = {32'h0, 32'h77};
      id_i_inst = 32'h30220001;
      #1;
      chk("load_stall_ready", id_i_ready, 1'b0);
      step();
      chk("load_bubble", id_o_valid, 1'b0);
      fwd_load = 2'b00;
`ifndef ID_FWD_EN
      #1;
      chk("nofwd_match_ready", id_i_ready, 1'b0);
      step();
      fwd_wreg = 2'b00;
`endif
      step();
      chk("load_accept_valid", id_o_valid, 1'b1);
`ifdef ID_FWD_EN
      chk("load_accept_reg0", id_o_reg0, 32'h77);
`else
      chk("load_accept_reg0", id_o_reg0, rf[1]);
`endif

      // Backpressure then flush
      idle_fwd();
      id_i_inst = 32'h3401FF00;
      step();
      id_o_ready = 0;
      id_i_inst = 32'h00221825;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_valid", id_o_valid, 1'b1);
         chk("bp_reg1", id_o_reg1, 32'h0000FF00);
         chk("bp_ready", id_i_ready, 1'b0);
      end
      flush = 1;
      #1;
      chk("flush_ready", id_i_ready, 1'b1);
      step();
      chk("flush_valid", id_o_valid, 1'b0);
      flush = 0; id_o_ready = 1;

      // Undecodable opcode
      id_i_inst = 32'hFC000000;
      step();
      chk("ill_illegal", id_o_illegal, 1'b1);
      chk("ill_wreg", id_o_wreg, 1'b0);
      chk("ill_alu_op", id_o_alu_op, 8'h00);

      // Reset in the middle of a stall with a held output
      id_i_inst = 32'h3401FF00;
      step();
      id_o_ready = 0;
      fwd_wreg = 2'b01; fwd_waddr = {5'd0, 5'd1}; fwd_load = 2'b01;
      id_i_inst = 32'h30220001;
      step();
      rst_ = 0;
      step();
      chk("rst_mid_valid", id_o_valid, 1'b0);
      chk("rst_mid_reg1", id_o_reg1, 32'h0);
      chk("rst_mid_wreg", id_o_wreg, 1'b0);
      chk("rst_mid_pc", id_o_pc, 32'h0);
      rst_ = 1; id_o_ready = 1;

      for (int c = 0; c < 3000; c++) begin
         rst_       = ($urandom_range(0, 99) != 0);
         flush      = ($urandom_range(0, 19) == 0);
         id_i_valid = ($urandom_range(0, 3) != 0);
         id_o_ready = ($urandom_range(0, 3) != 0);
         id_i_inst  = rand_inst();
         id_i_pc    = $urandom;
         fwd_wreg   = 2'($urandom);
         fwd_load   = 2'($urandom_range(0, 3) == 0 ? $urandom : 0);
         fwd_waddr  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         fwd_wdata  = {32'($urandom), 32'($urandom)};
         if ($urandom_range(0, 7) == 0) rf[$urandom_range(0, 3)] = $urandom;
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
